bus_mapper: RTL and testbench

Parametrised paged bus-to-physical memory mapper with an access sequencer. It sits between the CPU bus and the `sram` controller and generalises the fixed BK0010/BK0011M page map into WINDOWS runtime-programmable windows, each with valid and read-only flags. It adds a cycle-accurate legacy contention slot, a full request/ready/ack handshake and a fault report.

---
 rtl/bus_mapper.sv | 224 ++++++++++++++++++++++
 tb/tb_bus_mapper.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mapper.sv
// bus_mapper -- paged CPU-bus to physical-memory mapper with access sequencer.
//
// The 16-bit CPU byte address space is split into WINDOWS = 2^(16-WIN_BITS)
// windows. Each window has a runtime-programmable map entry {valid, ro, page}.
// A memory access is translated through the entry of its window. It is then
// paced by an optional contention slot and issued to the sram controller as a
// one-cycle request. Completion is signalled back with bus_ack.
//
// Optional feature macro: MAPPER_CONTENTION_EN
//   defined   : free-running slot counter on `ce`; non-turbo accesses are
//               released only at the end of each SLOT_LEN frame.
//   undefined : no counter; SLOT lasts one cycle; `ce` and `turbo` unused.
//
// Ports
//   clk_sys, reset        clock, asynchronous active-high reset
//   ce, turbo             contention timebase enable / contention bypass
//   bus_addr/din/wtbt/we  CPU address, write data, byte enables, write
//   bus_sync, bus_stb     address-phase valid, data strobe
//   map_sel               access targets the map register file
//   bus_ack, bus_dout     transfer done, read data (zero outside ACK)
//   fault                 one-cycle pulse on a rejected memory access
//   phys_addr/din/wtbt    translated address (LSB 0), write data, byte enables
//   phys_we, phys_rd      one-cycle write / read request
//   phys_dout, phys_ready sram read data and completion
module bus_mapper #(
  parameter int unsigned WIN_BITS = 13,
  parameter int unsigned PHYS_W   = 25,
  parameter int unsigned PAGE_W   = PHYS_W - WIN_BITS,
  parameter int unsigned SLOT_LEN = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              turbo,
  input  logic [15:0]       bus_addr,
  input  logic [15:0]       bus_din,
  input  logic [1:0]        bus_wtbt,
  input  logic              bus_we,
  input  logic              bus_sync,
  input  logic              bus_stb,
  input  logic              map_sel,
  output logic              bus_ack,
  output logic [15:0]       bus_dout,
  output logic              fault,
  output logic [PHYS_W-1:0] phys_addr,
  output logic [15:0]       phys_din,
  output logic [1:0]        phys_wtbt,
  output logic              phys_we,
  output logic              phys_rd,
  input  logic [15:0]       phys_dout,
  input  logic              phys_ready
);

  localparam int unsigned IDX_W   = 16 - WIN_BITS;
  localparam int unsigned WINDOWS = 1 << IDX_W;
  localparam int unsigned ENT_W   = PAGE_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_SLOT, S_ISSUE, S_WAIT, S_ACK, S_REG, S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ENT_W-1:0]    map_q [WINDOWS];
  logic [ENT_W-1:0]    map_d [WINDOWS];
  logic [PHYS_W-1:0]   phys_addr_q, phys_addr_d;
  logic                we_q, we_d;
  logic [1:0]          wtbt_q, wtbt_d;
  logic [15:0]         din_q, din_d;
  logic [15:0]         dout_q, dout_d;
  logic                fault_q, fault_d;
  logic                drop_q, drop_d;

  logic                grant;
  logic [ENT_W-1:0]    win_ent;
  logic [ENT_W-1:0]    reg_ent;
  logic [IDX_W-1:0]    reg_idx;
  logic [15:0]         reg_rd;
  logic                reject;
  state_t              done_state;
  logic                unused_lsb;

  always_comb unused_lsb = bus_addr[0];

`ifdef MAPPER_CONTENTION_EN
  localparam int unsigned CNT_W = $clog2(SLOT_LEN);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // SLOT_LEN is a power of two, so natural overflow is the modulo wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (ce) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb grant = turbo || (ce && (cnt_q == CNT_W'(SLOT_LEN - 1)));
`else
  logic unused_ctl;
  always_comb unused_ctl = ce ^ turbo;
  always_comb grant = 1'b1;
`endif

  // Window entry for translation and register-file entry for map access.
  always_comb begin
    win_ent = map_q[bus_addr[15:WIN_BITS]];
    reg_idx = bus_addr[IDX_W:1];
    reg_ent = map_q[reg_idx];
    reg_rd  = '0;
    reg_rd[15]         = reg_ent[ENT_W-1];
    reg_rd[14]         = reg_ent[ENT_W-2];
    reg_rd[PAGE_W-1:0] = reg_ent[PAGE_W-1:0];
    reject  = !win_ent[ENT_W-1] || (bus_we && win_ent[ENT_W-2]);
  end

  // An access whose strobe went away at any point before completion is
  // finished internally but never acknowledged.
  always_comb done_state = (drop_q || !bus_stb) ? S_IDLE : S_ACK;

  always_comb begin
    state_d     = state_q;
    map_d       = map_q;
    phys_addr_d = phys_addr_q;
    we_d        = we_q;
    wtbt_d      = wtbt_q;
    din_d       = din_q;
    dout_d      = dout_q;
    fault_d     = 1'b0;
    drop_d      = drop_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus_sync && bus_stb) begin
          drop_d = 1'b0;
          dout_d = '0;
          if (map_sel) begin
            state_d = S_REG;
            if (bus_we) begin
              if (bus_wtbt == 2'b11)
                map_d[reg_idx] = {bus_din[15], bus_din[14], bus_din[PAGE_W-1:0]};
            end else begin
              dout_d = reg_rd;
            end
          end else if (reject) begin
            fault_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            state_d     = S_SLOT;
            phys_addr_d = {win_ent[PAGE_W-1:0], bus_addr[WIN_BITS-1:1], 1'b0};
            we_d        = bus_we;
            wtbt_d      = bus_wtbt;
            din_d       = bus_din;
          end
        end
      end
      S_SLOT: begin
        if (!bus_stb) drop_d = 1'b1;
        if (grant) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!bus_stb) drop_d = 1'b1;
        if (we_q && (wtbt_q == 2'b00)) state_d = done_state;
        else                           state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!bus_stb) drop_d = 1'b1;
        if (phys_ready) begin
          dout_d  = phys_dout;
          state_d = done_state;
        end
      end
      S_REG: begin
        if (!bus_stb) drop_d = 1'b1;
        state_d = done_state;
      end
      S_ACK: begin
        if (!bus_stb) state_d = S_IDLE;
      end
      S_HOLD: begin
        if (!bus_stb) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phys_addr_q <= '0;
      we_q        <= 1'b0;
      wtbt_q      <= '0;
      din_q       <= '0;
      dout_q      <= '0;
      fault_q     <= 1'b0;
      drop_q      <= 1'b0;
      for (int unsigned i = 0; i < WINDOWS; i++)
        map_q[IDX_W'(i)] <= {1'b1, 1'b0, PAGE_W'(i)};
    end else begin
      state_q     <= state_d;
      phys_addr_q <= phys_addr_d;
      we_q        <= we_d;
      wtbt_q      <= wtbt_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      fault_q     <= fault_d;
      drop_q      <= drop_d;
      map_q       <= map_d;
    end
  end

  always_comb begin
    bus_ack   = (state_q == S_ACK);
    bus_dout  = (state_q == S_ACK) ? dout_q : '0;
    fault     = fault_q;
    phys_addr = phys_addr_q;
    phys_din  = din_q;
    phys_wtbt = wtbt_q;
    phys_rd   = (state_q == S_ISSUE) && !we_q;
    phys_we   = (state_q == S_ISSUE) && we_q && (wtbt_q != 2'b00);
  end

endmodule

// File: tb/tb_bus_mapper.sv
module tb_bus_mapper;
  localparam int WB = 13, PW = 25, PGW = 12, SL = 8;

  logic          clk_sys = 1'b0, reset = 1'b1, ce = 1'b0, turbo = 1'b1;
  logic [15:0]   bus_addr = '0, bus_din = '0;
  logic [1:0]    bus_wtbt = '0;
  logic          bus_we = 1'b0, bus_sync = 1'b0, bus_stb = 1'b0, map_sel = 1'b0;
  logic          bus_ack, fault, phys_we, phys_rd;
  logic [15:0]   bus_dout, phys_din;
  logic [PW-1:0] phys_addr;
  logic [1:0]    phys_wtbt;
  logic [15:0]   phys_dout = '0;
  logic          phys_ready = 1'b0;

  bus_mapper #(.WIN_BITS(WB), .PHYS_W(PW), .PAGE_W(PGW), .SLOT_LEN(SL)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .turbo(turbo),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_wtbt(bus_wtbt), .bus_we(bus_we),
    .bus_sync(bus_sync), .bus_stb(bus_stb), .map_sel(map_sel),
    .bus_ack(bus_ack), .bus_dout(bus_dout), .fault(fault),
    .phys_addr(phys_addr), .phys_din(phys_din), .phys_wtbt(phys_wtbt),
    .phys_we(phys_we), .phys_rd(phys_rd), .phys_dout(phys_dout), .phys_ready(phys_ready)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Map model: plain arrays of the architectural fields.
  logic mdl_valid [8];
  logic mdl_ro    [8];
  int   mdl_page  [8];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mdl_valid[i] = 1'b1; mdl_ro[i] = 1'b0; mdl_page[i] = i;
    end
  endtask

  // Expectation for the access in flight: 0 none, 1 read, 2 write.
  int            exp_kind = 0;
  logic [PW-1:0] exp_paddr = '0;
  logic [15:0]   exp_din = '0;
  logic [1:0]    exp_wtbt = '0;
  int            req_seen = 0;
  logic [PW-1:0] last_paddr = '0;
  int            resp_k = 1;
  logic          resp_en = 1'b1;
  logic [15:0]   sram_rdata = '0;
  logic          chk_align = 1'b0;

  // Contention timebase: ce high one clock in four.
  int ce_phase = 0;
  initial forever begin
    @(posedge clk_sys); #1;
    ce_phase = (ce_phase + 1) % 4;
    ce = (ce_phase == 3);
  end

`ifdef MAPPER_CONTENTION_EN
  int   ce_edges = 0;
  logic last_ce = 1'b0;
  always @(posedge clk_sys) begin
    if (reset) begin ce_edges = 0; last_ce = 1'b0; end
    else begin
      last_ce = ce;
      if (ce) ce_edges = ce_edges + 1;
    end
  end
`endif

  // sram responder: phys_ready resp_k cycles after the request cycle.
  initial forever begin
    @(negedge clk_sys);
    if (!reset && resp_en && (phys_rd || phys_we)) begin
      repeat (resp_k) @(negedge clk_sys);
      phys_dout = sram_rdata; phys_ready = 1'b1;
      @(negedge clk_sys);
      phys_ready = 1'b0; phys_dout = '0;
    end
  end

  // Per-cycle compare against the model expectation.
  initial forever begin
    @(negedge clk_sys);
    if (!reset) begin
      check("rd_we_excl", {31'b0, phys_rd & phys_we}, 0);
      if (!bus_ack) check("dout_zero", {16'b0, bus_dout}, 0);
      if (phys_rd || phys_we) begin
        req_seen++;
        last_paddr = phys_addr;
        check("req_kind", phys_we ? 2 : 1, exp_kind);
        check("paddr", {7'b0, phys_addr}, {7'b0, exp_paddr});
        if (phys_we) begin
          check("pdin", {16'b0, phys_din}, {16'b0, exp_din});
          check("pwtbt", {30'b0, phys_wtbt}, {30'b0, exp_wtbt});
        end
`ifdef MAPPER_CONTENTION_EN
        if (chk_align) check("slot_align", {30'b0, (ce_edges % 8) == 0, last_ce}, 2'b11);
`endif
      end
    end
  end

  task automatic set_exp(input logic [15:0] a, input logic [15:0] d, input logic [1:0] wt,
                         input logic we, output logic rej);
    int ai, idx;
    ai = a; idx = ai / 8192;
    rej = !mdl_valid[idx] || (we && mdl_ro[idx]);
    exp_paddr = PW'(mdl_page[idx] * 8192 + (ai % 8192) - (ai % 2));
    exp_din = d; exp_wtbt = wt;
    exp_kind = rej ? 0 : (we ? ((wt != 2'b00) ? 2 : 0) : 1);
  endtask

  // Called at a negedge; drives immediately, then follows the access to completion.
  task automatic access(input string tag, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] wt, input logic we, input logic ms,
                        output int lat_req, output int lat_ack);
    logic rej; int req0, fcnt, budget, ai;
    logic [15:0] rd, mval;
    ai = a;
    rej = 1'b0;
    if (ms) begin
      exp_kind = 0;
      mval = {mdl_valid[(ai / 2) % 8], mdl_ro[(ai / 2) % 8], 14'(mdl_page[(ai / 2) % 8])};
    end else begin
      set_exp(a, d, wt, we, rej);
      mval = '0;
    end
    req0 = req_seen; lat_req = -1; lat_ack = -1; rd = '0; fcnt = 0;
    bus_addr = a; bus_din = d; bus_wtbt = wt; bus_we = we; map_sel = ms;
    bus_sync = 1'b1; bus_stb = 1'b1;
    budget = rej ? 12 : 100;
    for (int s = 1; s <= budget; s++) begin
      @(negedge clk_sys);
      if ((phys_rd || phys_we) && lat_req < 0) lat_req = s;
      if (fault) fcnt++;
      if (bus_ack) begin lat_ack = s; rd = bus_dout; break; end
    end
    bus_sync = 1'b0; bus_stb = 1'b0; bus_we = 1'b0; map_sel = 1'b0;
    @(negedge clk_sys);
    check({tag, "_ack_release"}, {31'b0, bus_ack}, 0);
    if (ms) begin
      check({tag, "_reg_lat"}, lat_ack, 2);
      check({tag, "_reg_noreq"}, req_seen - req0, 0);
      if (!we) check({tag, "_reg_rd"}, {16'b0, rd}, {16'b0, mval});
      else if (wt == 2'b11) begin
        mdl_valid[(ai / 2) % 8] = d[15];
        mdl_ro[(ai / 2) % 8]    = d[14];
        mdl_page[(ai / 2) % 8]  = d[11:0];
      end
    end else if (rej) begin
      check({tag, "_fault"}, fcnt, 1);
      check({tag, "_no_ack"}, lat_ack, -1);
      check({tag, "_no_req"}, req_seen - req0, 0);
    end else begin
      check({tag, "_ack"}, {31'b0, lat_ack > 0}, 1);
      check({tag, "_no_fault"}, fcnt, 0);
      check({tag, "_nreq"}, req_seen - req0, (exp_kind != 0) ? 1 : 0);
      if (!we) check({tag, "_rdata"}, {16'b0, rd}, {16'b0, sram_rdata});
    end
    exp_kind = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, {31'b0, bus_ack}, 0);
    check({tag, "_fault"}, {31'b0, fault}, 0);
    check({tag, "_we"}, {31'b0, phys_we}, 0);
    check({tag, "_rd"}, {31'b0, phys_rd}, 0);
    check({tag, "_paddr"}, {7'b0, phys_addr}, 0);
    check({tag, "_dout"}, {16'b0, bus_dout}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lr, la, n;
    logic rej;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    // Identity map: 0o040000 -> window 2 -> 0x4000.
    sram_rdata = 16'hA5A5; resp_k = 1;
    access("rd4000", 16'o040000, '0, 2'b11, 1'b0, 1'b0, lr, la);
    check("rd4000_paddr_lit", {7'b0, last_paddr}, 32'h0004000);
    check("rd4000_req_lat", lr, 2);
    check("rd4000_ack_lat", la, 4);

    sram_rdata = 16'h1234; resp_k = 3;
    access("rd_k3", 16'h2010, '0, 2'b11, 1'b0, 1'b0, lr, la);
    check("rd_k3_ack_lat", la, 6);
    resp_k = 1;

    // Remap window 2 to page 0x123.
    access("mw2", 16'h0004, 16'h8123, 2'b11, 1'b1, 1'b1, lr, la);
    access("mr2", 16'h0004, '0, 2'b11, 1'b0, 1'b1, lr, la);
    sram_rdata = 16'h0F0F;
    access("rd4002", 16'o040002, '0, 2'b11, 1'b0, 1'b0, lr, la);
    check("rd4002_paddr_lit", {7'b0, last_paddr}, 32'h0246002);

    // Read-only window 3 rejects writes but allows reads.
    access("mw3", 16'h0006, 16'hC003, 2'b11, 1'b1, 1'b1, lr, la);
    access("wr_ro", 16'o060000, 16'h5555, 2'b11, 1'b1, 1'b0, lr, la);
    access("rd_ro", 16'o060004, '0, 2'b11, 1'b0, 1'b0, lr, la);

    // Invalid window 5; a partial-width map write is ignored.
    access("mw5", 16'h000A, 16'h0005, 2'b11, 1'b1, 1'b1, lr, la);
    access("rd_inv", 16'hA000, '0, 2'b11, 1'b0, 1'b0, lr, la);
    access("mw5_part", 16'h000A, 16'h8005, 2'b01, 1'b1, 1'b1, lr, la);
    access("rd_inv2", 16'hA002, '0, 2'b11, 1'b0, 1'b0, lr, la);
    access("mr5", 16'h000A, '0, 2'b11, 1'b0, 1'b1, lr, la);

    // Write with no byte enables: ack without phys_we.
    access("wr_wt0", 16'h2000, 16'h1111, 2'b00, 1'b1, 1'b0, lr, la);
    check("wr_wt0_ack_lat", la, 3);
    access("wr_hi", 16'h2002, 16'hBEEF, 2'b10, 1'b1, 1'b0, lr, la);

    // Strobe dropped in flight: ready still consumed, no ack.
    resp_k = 3;
    set_exp(16'h2020, '0, 2'b11, 1'b0, rej);
    bus_addr = 16'h2020; bus_we = 1'b0; bus_wtbt = 2'b11; bus_sync = 1'b1; bus_stb = 1'b1;
    n = 0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk_sys);
      if (phys_rd) break;
    end
    bus_sync = 1'b0; bus_stb = 1'b0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk_sys);
      if (bus_ack) n++;
    end
    check("drop_no_ack", n, 0);
    exp_kind = 0; resp_k = 1;
    sram_rdata = 16'h7777;
    access("after_drop", 16'h2030, '0, 2'b11, 1'b0, 1'b0, lr, la);

`ifdef MAPPER_CONTENTION_EN
    turbo = 1'b0; chk_align = 1'b1;
    access("cont_rd", 16'h0040, '0, 2'b11, 1'b0, 1'b0, lr, la);
    for (int s = 0; s < 64; s++) begin
      @(negedge clk_sys);
      if ((ce_edges % 8) == 7 && ce) break;
    end
    access("wrap_rd", 16'h0042, '0, 2'b11, 1'b0, 1'b0, lr, la);
    check("wrap_full_frame", lr, 33);
    chk_align = 1'b0; turbo = 1'b1;
    access("turbo_rd", 16'h0044, '0, 2'b11, 1'b0, 1'b0, lr, la);
    check("turbo_req_lat", lr, 2);
`else
    turbo = 1'b0;
    access("noncont_rd", 16'h0040, '0, 2'b11, 1'b0, 1'b0, lr, la);
    check("noncont_req_lat", lr, 2);
    turbo = 1'b1;
`endif

    // Reset while waiting for sram.
    resp_en = 1'b0;
    set_exp(16'o040000, '0, 2'b11, 1'b0, rej);
    bus_addr = 16'o040000; bus_we = 1'b0; bus_sync = 1'b1; bus_stb = 1'b1;
    n = 0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk_sys);
      if (phys_rd) begin n = 1; break; end
    end
    check("wait_req_seen", n, 1);
    @(negedge clk_sys);
    check("wait_paddr_held", {7'b0, phys_addr}, 32'h0246000);
    reset = 1'b1;
    #1;
    check_all_zero("rst_wait");
    bus_sync = 1'b0; bus_stb = 1'b0;
    exp_kind = 0;
    @(negedge clk_sys);
    reset = 1'b0; resp_en = 1'b1;
    model_reset();
    @(negedge clk_sys);
    sram_rdata = 16'h4242;
    access("rd_post_rst", 16'o040000, '0, 2'b11, 1'b0, 1'b0, lr, la);
    check("post_rst_paddr_lit", {7'b0, last_paddr}, 32'h0004000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
